// File: rtl/multi_level_clock_gen_if.sv
// Control and strobe bundle for the multi-channel low/high clock generator.
// The level field for channel i is level[i*LEVEL_W +: LEVEL_W].
interface multi_level_clock_gen_if #(
  parameter int N_CH    = 2,
  parameter int LEVEL_W = 3
);
  logic [N_CH-1:0]         en;
  logic [N_CH-1:0]         mode;
  logic [N_CH-1:0]         trig;
  logic [N_CH*LEVEL_W-1:0] level;
  logic [N_CH-1:0]         CLKOUT;
  logic [N_CH-1:0]         rise;
  logic [N_CH-1:0]         done;

  modport master (
    output en, mode, trig, level,
    input  CLKOUT, rise, done
  );

  modport slave (
    input  en, mode, trig, level,
    output CLKOUT, rise, done
  );
endinterface

// File: rtl/multi_level_clock_gen.sv
// N independent channels, each producing a fixed low phase followed by a
// level-scaled high phase, in continuous or single-shot mode.
//
// state   | meaning
// IDLE    | CLKOUT=0, waiting for en (continuous) or en+trig (single-shot)
// LOW     | CLKOUT=0, counting LOW_CYCLES; en=0 aborts to IDLE
// HIGH    | CLKOUT=1, counting (lvl_q+1)*HIGH_STEP; always runs to completion
module multi_level_clock_gen #(
  parameter int N_CH       = 2,
  parameter int LEVEL_W    = 3,
  parameter int LOW_CYCLES = 30,
  parameter int HIGH_STEP  = 11
) (
  input logic                      CLK,
  input logic                      RST,
  multi_level_clock_gen_if.slave   bus
);

  localparam int HIGH_MAX = (2 ** LEVEL_W) * HIGH_STEP;
  localparam int CNT_MAX  = (LOW_CYCLES > HIGH_MAX) ? LOW_CYCLES : HIGH_MAX;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP      = CNT_W'(HIGH_STEP);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [LEVEL_W-1:0] lvl_q;
    logic               clk_q;
    logic               rise_q;
    logic               done_q;
    logic [CNT_W-1:0]   high_last;

    // CNT_W always holds 2**LEVEL_W*HIGH_STEP, so this product cannot wrap.
    assign high_last = (CNT_W'(lvl_q) + CNT_ONE) * STEP - CNT_ONE;

    always_ff @(posedge CLK) begin
      if (RST) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        lvl_q  <= '0;
        clk_q  <= 1'b0;
        rise_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        done_q <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (bus.en[i] && (!bus.mode[i] || bus.trig[i])) begin
              state <= ST_LOW;
              cnt   <= '0;
            end
          end
          ST_LOW: begin
            if (!bus.en[i]) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (cnt == LOW_LAST) begin
              state  <= ST_HIGH;
              cnt    <= '0;
              lvl_q  <= bus.level[i*LEVEL_W +: LEVEL_W];
              clk_q  <= 1'b1;
              rise_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_HIGH: begin
            if (cnt == high_last) begin
              clk_q <= 1'b0;
              cnt   <= '0;
              if (bus.mode[i]) begin
                state  <= ST_IDLE;
                done_q <= 1'b1;
              end else if (bus.en[i]) begin
                state <= ST_LOW;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
            clk_q <= 1'b0;
          end
        endcase
      end
    end

    assign bus.CLKOUT[i] = clk_q;
    assign bus.rise[i]   = rise_q;
    assign bus.done[i]   = done_q;
  end

endmodule

// File: tb/tb_multi_level_clock_gen.sv
// Self-checking bench: expected phase lengths are queued per channel as stimulus
// is applied and compared by a negedge monitor as pulses appear.
module tb_multi_level_clock_gen;

  localparam int N_CH    = 2;
  localparam int LEVEL_W = 3;

  typedef struct {
    int   low;    // expected low run before the rise, -1 = don't care
    int   high;   // expected high run length
    logic done;   // expected done strobe at the fall
  } exp_t;

  typedef struct {
    logic       mode;
    logic [2:0] level;
    int         npulses;
    int         exp_high;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multi_level_clock_gen_if #(.N_CH(N_CH), .LEVEL_W(LEVEL_W)) bus ();

  multi_level_clock_gen #(
    .N_CH(N_CH), .LEVEL_W(LEVEL_W), .LOW_CYCLES(30), .HIGH_STEP(11)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t exp_q[N_CH][$];
  logic prev_clk[N_CH];
  int   run_len[N_CH];
  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  // Monitor: measures run lengths of CLKOUT and checks strobes every cycle.
  always @(negedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        chk($sformatf("reset_out_ch%0d", ch),
            {29'd0, bus.CLKOUT[ch], bus.rise[ch], bus.done[ch]}, 0);
        prev_clk[ch] = 1'b0;
        run_len[ch]  = 0;
      end
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        logic c, is_rise, is_fall, exp_d;
        exp_t rec;
        c       = bus.CLKOUT[ch];
        is_rise = c && !prev_clk[ch];
        is_fall = !c && prev_clk[ch];
        exp_d   = 1'b0;
        if (is_rise) begin
          if (exp_q[ch].size() == 0) chk($sformatf("unexpected_rise_ch%0d", ch), 1, 0);
          else if (exp_q[ch][0].low >= 0)
            chk($sformatf("low_len_ch%0d", ch), run_len[ch], exp_q[ch][0].low);
          run_len[ch] = 0;
        end else if (is_fall) begin
          if (exp_q[ch].size() == 0) chk($sformatf("unexpected_fall_ch%0d", ch), 1, 0);
          else begin
            rec = exp_q[ch].pop_front();
            chk($sformatf("high_len_ch%0d", ch), run_len[ch], rec.high);
            exp_d = rec.done;
          end
          run_len[ch] = 0;
        end
        run_len[ch]++;
        chk($sformatf("rise_strobe_ch%0d", ch), int'(bus.rise[ch]), int'(is_rise));
        chk($sformatf("done_strobe_ch%0d", ch), int'(bus.done[ch]), int'(exp_d));
        prev_clk[ch] = c;
      end
    end
  end

  task automatic wait_empty(input int budget, input string name);
    int n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      chk(name, 0, 1);
      exp_q[0].delete();
      exp_q[1].delete();
    end
  endtask

  task automatic wait_high(input int ch, input int budget, input string name);
    int n = 0;
    while (!bus.CLKOUT[ch] && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= budget) chk(name, 0, 1);
  endtask

  task automatic push(input int ch, input int low, input int high, input logic d);
    exp_t e;
    e.low  = low;
    e.high = high;
    e.done = d;
    exp_q[ch].push_back(e);
  endtask

  initial begin
    vecs[0] = '{mode: 1'b0, level: 3'd0, npulses: 2, exp_high: 11};
    vecs[1] = '{mode: 1'b0, level: 3'd7, npulses: 2, exp_high: 88};
    vecs[2] = '{mode: 1'b0, level: 3'd4, npulses: 1, exp_high: 55};
    vecs[3] = '{mode: 1'b0, level: 3'd1, npulses: 1, exp_high: 22};

    bus.en    = 2'b01;
    bus.mode  = 2'b00;
    bus.trig  = 2'b00;
    bus.level = '0;
    repeat (3) @(negedge clk);
    #1;

    // Continuous ch0 across levels; level changes land during LOW.
    for (int i = 0; i < 4; i++) begin
      bus.mode[0]      = vecs[i].mode;
      bus.level[2:0]   = vecs[i].level;
      for (int p = 0; p < vecs[i].npulses; p++) push(0, 30, vecs[i].exp_high, 1'b0);
      if (i == 0) rst = 1'b0;
      wait_empty(150 * vecs[i].npulses, $sformatf("timeout_vec%0d", i));
    end

    // Level change mid-HIGH only affects the following pulse.
    bus.level[2:0] = 3'd2;
    push(0, 30, 33, 1'b0);
    push(0, 30, 66, 1'b0);
    wait_high(0, 100, "timeout_lvl_rise");
    repeat (5) @(negedge clk);
    #1 bus.level[2:0] = 3'd5;
    wait_empty(300, "timeout_lvl_change");

    // en falls mid-HIGH: full pulse, then silence.
    bus.level[2:0] = 3'd3;
    push(0, 30, 44, 1'b0);
    wait_high(0, 100, "timeout_enoff_rise");
    repeat (5) @(negedge clk);
    #1 bus.en[0] = 1'b0;
    wait_empty(100, "timeout_enoff_high");
    repeat (150) @(negedge clk);
    #1 chk("ch0_idle_after_en_high", int'(bus.CLKOUT[0]), 0);

    // en falls mid-LOW: no pulse at all.
    bus.en[0] = 1'b1;
    repeat (10) @(negedge clk);
    #1 bus.en[0] = 1'b0;
    repeat (80) @(negedge clk);
    #1 chk("ch0_idle_after_en_low", int'(bus.CLKOUT[0]), 0);

    // Single-shot on ch1: needs trig, ends with done, trig in HIGH ignored.
    bus.level[5:3] = 3'd1;
    bus.mode[1]    = 1'b1;
    bus.en[1]      = 1'b1;
    repeat (20) @(negedge clk);
    #1 chk("ch1_waits_for_trig", int'(bus.CLKOUT[1]), 0);
    push(1, -1, 22, 1'b1);
    bus.trig[1] = 1'b1;
    @(negedge clk);
    #1 bus.trig[1] = 1'b0;
    wait_high(1, 100, "timeout_shot_rise");
    repeat (3) @(negedge clk);
    #1 bus.trig[1] = 1'b1;
    @(negedge clk);
    #1 bus.trig[1] = 1'b0;
    wait_empty(100, "timeout_shot_high");
    repeat (60) @(negedge clk);
    #1 chk("ch1_idle_after_shot", int'(bus.CLKOUT[1]), 0);

    // Reset while ch0 is HIGH and ch1 is LOW, then independent restart.
    bus.en[1]      = 1'b0;
    bus.mode       = 2'b00;
    bus.level[5:3] = 3'd7;
    bus.level[2:0] = 3'd0;
    push(0, -1, 11, 1'b0);
    bus.en[0] = 1'b1;
    wait_high(0, 100, "timeout_rst_setup");
    bus.en[1] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_ch0_high", int'(bus.CLKOUT[0]), 1);
    chk("pre_rst_ch1_low", int'(bus.CLKOUT[1]), 0);
    exp_q[0].delete();
    exp_q[1].delete();
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    for (int p = 0; p < 3; p++) push(0, 30, 11, 1'b0);
    push(1, 30, 88, 1'b0);
    wait_empty(400, "timeout_post_rst");
    bus.en = 2'b00;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
